// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the pc, drives the instruction memory and queues
// {pc, instr} pairs for decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_en,
    input  logic                      redirect,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic [XLEN-1:0]           imem_addr,
    output logic                      imem_en,
    input  logic [XLEN-1:0]           imem_data,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [XLEN-1:0]           dec_instr,
    output logic [XLEN-1:0]           dec_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                      fetch_fault,
    output logic [XLEN-1:0]           fault_pc,
`endif
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_mem    [QDEPTH];
    logic [XLEN-1:0]  instr_mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             q_nonempty;
    logic             pop;
    logic             push;
    logic             halt;

    // Handshake: an entry transfers to decode on a cycle where dec_valid and
    // dec_ready are both high; dec_valid never depends on dec_ready.
    assign q_nonempty = (count != '0);
    assign dec_valid  = q_nonempty & ~redirect;
    assign dec_instr  = q_nonempty ? instr_mem[rd_ptr] : '0;
    assign dec_pc     = q_nonempty ? pc_mem[rd_ptr]    : '0;
    assign pop        = dec_valid & dec_ready;

    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign imem_en    = fetch_en & ~redirect & ~reset & ~halt & ((count != FULL_CNT) | pop);
    assign push       = imem_en;
    assign imem_addr  = pc;
    assign q_count    = count;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    logic fault_r;

    assign misaligned  = |redirect_pc[1:0];
    assign halt        = fault_r;
    assign fetch_fault = fault_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_r  <= 1'b0;
            fault_pc <= '0;
        end else if (redirect) begin
            fault_r <= misaligned;
            if (misaligned) begin
                fault_pc <= redirect_pc;
            end
        end
    end
`else
    logic [1:0] unused_redirect_low;

    assign halt                = 1'b0;
    assign unused_redirect_low = redirect_pc[1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            // A misaligned target leaves pc untouched; fetch stays halted until an aligned redirect.
            if (!misaligned) begin
                pc <= redirect_pc;
            end
`else
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
`endif
        end else begin
            if (push) begin
                pc     <= pc + XLEN'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what decode can see.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  q_count;

    logic [31:0] imem_addr2;
    logic        imem_en2;
    logic [31:0] imem_data2;
    logic        dec_valid2;
    logic [31:0] dec_instr2;
    logic [31:0] dec_pc2;
    logic [2:0]  q_count2;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic        fetch_fault2;
    logic [31:0] fault_pc2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pc2;
    logic        m_fault;
    logic [31:0] m_fpc;

    // Values seen at the most recent step, for directed constant checks
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_addr;
    logic        obs_en;
    logic [2:0]  obs_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_data  = mem_word(imem_addr);
    assign imem_data2 = mem_word(imem_addr2);

    fetch_queue_unit #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault(fetch_fault), .fault_pc(fault_pc),
`endif
        .q_count(q_count)
    );

    fetch_queue_unit #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(1'b1), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_addr(imem_addr2), .imem_en(imem_en2),
        .imem_data(imem_data2), .dec_valid(dec_valid2), .dec_ready(1'b1),
        .dec_instr(dec_instr2), .dec_pc(dec_pc2),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault(fetch_fault2), .fault_pc(fault_pc2),
`endif
        .q_count(q_count2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc    = 32'h0000_0000;
        m_pc2   = 32'hFFFF_FFF8;
        m_fault = 1'b0;
        m_fpc   = 32'h0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, clock.
    task automatic step(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic        e_valid;
        logic        e_pop;
        logic        e_push;
        logic [63:0] head;
        fetch_en    = fe;
        dec_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        head    = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
        e_valid = (exp_q.size() > 0) && !rd;
        e_pop   = e_valid && rdy;
        e_push  = fe && !rd && !m_fault && ((exp_q.size() < 4) || e_pop);
        check("dec_valid", {63'h0, dec_valid}, {63'h0, e_valid});
        check("dec_pc", {32'h0, dec_pc}, {32'h0, head[63:32]});
        check("dec_instr", {32'h0, dec_instr}, {32'h0, head[31:0]});
        check("q_count", {61'h0, q_count}, 64'(exp_q.size()));
        check("imem_en", {63'h0, imem_en}, {63'h0, e_push});
        check("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
        check("wrap_addr", {32'h0, imem_addr2}, {32'h0, m_pc2});
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
        check("fault_pc", {32'h0, fault_pc}, {32'h0, m_fpc});
`endif
        obs_valid = dec_valid;
        obs_pc    = dec_pc;
        obs_addr  = imem_addr;
        obs_en    = imem_en;
        obs_cnt   = q_count;
        if (rd) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_fpc   = rpc;
            end else begin
                m_fault = 1'b0;
                m_pc    = rpc;
            end
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (e_pop) void'(exp_q.pop_front());
            if (e_push) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_pc2 = m_pc2 + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("rst_q_count", {61'h0, q_count}, 64'h0);
        check("rst_imem_en", {63'h0, imem_en}, 64'h0);
        check("rst_imem_addr", {32'h0, imem_addr}, 64'h0);
        check("rst_dec_pc", {32'h0, dec_pc}, 64'h0);
        check("rst_dec_instr", {32'h0, dec_instr}, 64'h0);
        check("rst_wrap_addr", {32'h0, imem_addr2}, 64'hFFFF_FFF8);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        fetch_en    = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Streaming: one instruction per cycle, queue never above one entry.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (k >= 1) check("stream_pc", {32'h0, obs_pc}, 64'(4 * (k - 1)));
            check("stream_cnt_le1", {63'h0, (obs_cnt <= 3'd1)}, 64'h1);
        end

        // Back-pressure: fill, hold, then drain in order with no gap.
        pulse_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("full_count", {61'h0, q_count}, 64'h4);
        check("full_en", {63'h0, imem_en}, 64'h0);
        check("full_addr", {32'h0, imem_addr}, 64'h10);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("drain_pc", {32'h0, obs_pc}, 64'(4 * k));
        end

        // Redirect with three queued entries.
        pulse_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check("redir_valid", {63'h0, obs_valid}, 64'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_cnt", {61'h0, obs_cnt}, 64'h0);
        check("redir_addr", {32'h0, obs_addr}, 64'h200);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_pc", {32'h0, obs_pc}, 64'h200);
        check("redir_valid2", {63'h0, obs_valid}, 64'h1);

        // Reset mid-burst with a full queue.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_rst_full", {61'h0, q_count}, 64'h4);
        pulse_reset();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 32'($urandom_range(0, 1023)));
        end

        // Misaligned redirect followed by an aligned one.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_en", {63'h0, obs_en}, 64'h0);
        check("trap_fault", {63'h0, fetch_fault}, 64'h1);
        check("trap_fpc", {32'h0, fault_pc}, 64'h102);
`else
        check("mis_addr", {32'h0, obs_addr}, 64'h100);
        check("mis_en", {63'h0, obs_en}, 64'h1);
`endif
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("align_addr", {32'h0, obs_addr}, 64'h100);
        check("align_en", {63'h0, obs_en}, 64'h1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("align_pc", {32'h0, obs_pc}, 64'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address and enable.
- Captures the combinational read data into a small FIFO of {pc, instr} pairs.
- Presents queued instructions to decode over a valid/ready handshake; supports branch redirect (flush) and fetch back-pressure.

Parameters:
- XLEN, 32, width of pc, memory address and instruction data
- QDEPTH, 4, instruction queue entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, pc value loaded on reset; must be 4-byte aligned

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_en  input  1  permits new fetches; when low the queue still drains
- redirect  input  1  branch/jump taken; flush and reload pc
- redirect_pc  input  XLEN  new fetch address, valid when redirect=1
- imem_addr  output  XLEN  byte address to instruction memory (memory indexes addr[XLEN-1:2])
- imem_en  output  1  fetch request this cycle
- imem_data  input  XLEN  instruction word, combinational from imem_addr in the same cycle
- dec_valid  output  1  head entry available to decode
- dec_ready  input  1  decode accepts head entry
- dec_instr  output  XLEN  head instruction
- dec_pc  output  XLEN  pc of head instruction
- q_count  output  $clog2(QDEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, queue empty, read/write pointers=0, q_count=0
  - imem_en=0 while reset is high, dec_valid=0, dec_instr=0, dec_pc=0
  - imem_addr=RESET_PC
- imem_addr = pc at all times; pc[1:0] is always 00.
- pop = dec_valid & dec_ready.
- push = imem_en, where imem_en = fetch_en & ~redirect & ~reset & (q_count<QDEPTH | pop).
- On push, at the rising edge:
  - write {pc, imem_data} at the write pointer
  - pc <= pc+4, modulo 2^XLEN: 32'hFFFF_FFFC wraps to 0
- Fetch latency: the instruction presented at cycle N is visible on dec_* from cycle N+1 when the queue was empty (one register stage). Sustained throughput is one instruction per cycle.
- Simultaneous push and pop:
  - allowed in every state, including full
  - q_count unchanged
- Full (q_count=QDEPTH) with no pop: imem_en=0; pc holds.
- Empty: dec_valid=0; dec_instr and dec_pc are driven to 0, never stale data.
- Redirect (highest priority):
  - dec_valid forced 0 in the redirect cycle, so no transfer occurs
  - at the edge: queue cleared (pointers and q_count to 0), pc <= redirect_pc with low two bits handled per the optional feature
  - no push in the redirect cycle
  - the first fetch from the new target occurs the following cycle if fetch_en=1
- Back-to-back redirects: the last one wins; every redirect flushes.
- fetch_en low: no push and pc holds; pops continue until empty.
- Reset asserted mid-stream: all state is discarded immediately, and nothing queued survives.
- Pointers wrap modulo QDEPTH; full and empty are distinguished by q_count.
- No combinational path from dec_ready to dec_valid. A path from redirect to dec_valid is permitted.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - adds output fetch_fault (1 bit, reset 0) and output fault_pc (XLEN, reset 0)
  - a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 and captures fault_pc=redirect_pc
  - the queue is flushed and imem_en stays 0
  - fetch_fault holds until an aligned redirect clears it and resumes fetch at that target
- When undefined:
  - ports are absent
  - redirect_pc[1:0] is ignored; pc loads {redirect_pc[XLEN-1:2], 2'b00}

Test Plan:
- Reset, then fetch_en=1, dec_ready=1, memory word i = 32'h1000_0000+i → dec_pc 0,4,8,... one per cycle from the 2nd cycle after reset release; dec_instr matches; q_count never exceeds 1.
- dec_ready=0 for 10 cycles with fetch_en=1 → q_count reaches 4 and holds, imem_en=0, imem_addr=16. Then dec_ready=1 → entries pc 0,4,8,12 drain in order, and fetch resumes at 16 with no gap or duplicate.
- Queue holding 3 entries, redirect=1 with redirect_pc=32'h0000_0200 → dec_valid=0 that cycle, q_count=0 next cycle, next dec_pc=32'h200; no pre-redirect instruction is ever accepted.
- RESET_PC=32'hFFFF_FFF8 → fetches at FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Reset pulsed asynchronously mid-burst with a full queue → dec_valid, q_count and imem_en drop to 0 before the next clock edge; pc=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN defined, redirect_pc=32'h0000_0102 → fetch_fault=1, fault_pc=32'h102, imem_en=0. A later redirect to 32'h0000_0100 → fault cleared, fetch at 32'h100. Without the macro, the same stimulus → fetch at 32'h100.
